// File: rtl/alu_muldiv_seq_pkg.sv
// Shared types and helpers for the iterative multiply/divide unit.
// Helpers work on MD_W_MAX-bit words; callers cast to their own width.
package lib_muldiv;

  localparam int unsigned MD_W_MAX     = 128;
  localparam int unsigned MD_TAG_W_MAX = 16;

  typedef enum logic [2:0] {
    OpMul    = 3'd0,
    OpMulh   = 3'd1,
    OpMulhsu = 3'd2,
    OpMulhu  = 3'd3,
    OpDiv    = 3'd4,
    OpDivu   = 3'd5,
    OpRem    = 3'd6,
    OpRemu   = 3'd7
  } MD_OP;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } MD_STATE;

  typedef struct packed {
    MD_OP                    op;
    logic [MD_W_MAX-1:0]     a;
    logic [MD_W_MAX-1:0]     b;
    logic [MD_TAG_W_MAX-1:0] tag;
  } MD_REQ;

  // Whether operand a (is_b=0) or b (is_b=1) is interpreted as signed.
  function automatic logic fn_md_is_signed(input MD_OP op, input logic is_b);
    logic s;
    unique case (op)
      OpMul, OpMulh, OpDiv, OpRem: s = 1'b1;
      OpMulhsu:                    s = ~is_b;
      default:                     s = 1'b0;
    endcase
    return s;
  endfunction

  function automatic logic [MD_W_MAX-1:0] fn_md_neg(input logic [MD_W_MAX-1:0] v);
    return -v;
  endfunction

  // Magnitude of a w-bit value held zero-extended; low w bits of the result are valid.
  function automatic logic [MD_W_MAX-1:0] fn_md_abs(input logic [MD_W_MAX-1:0] v,
                                                    input logic sgn, input int unsigned w);
    return (sgn && v[w-1]) ? fn_md_neg(v) : v;
  endfunction

endpackage

// File: rtl/alu_muldiv_seq_if.sv
// Request/response handshake bundle for alu_muldiv_seq.
interface alu_muldiv_seq_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
) ();
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic [XLEN-1:0]  req_a;
  logic [XLEN-1:0]  req_b;
  logic [TAG_W-1:0] req_tag;
  logic             resp_valid;
  logic             resp_ready;
  logic [XLEN-1:0]  resp_data;
  logic [TAG_W-1:0] resp_tag;

  modport master (
    output req_valid, req_op, req_a, req_b, req_tag, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_tag
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_tag, resp_ready,
    output req_ready, resp_valid, resp_data, resp_tag
  );
endinterface

// File: rtl/alu_muldiv_seq.sv
// Iterative radix-2 MUL/MULH*/DIV/REM unit, one op in flight, valid/ready both sides.
// Optional MULDIV_EARLY_OUT_EN: multiply exits RUN once remaining multiplier bits are zero.
module alu_muldiv_seq
  import lib_muldiv::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  alu_muldiv_seq_if.slave  bus,
  output logic             busy
);

  localparam int unsigned CntW = $clog2(XLEN);
  localparam int unsigned PW   = 2 * XLEN;

  MD_STATE r_state, w_state_next;
  MD_REQ   w_req;
  MD_OP    r_op;

  logic [TAG_W-1:0] r_tag;
  logic             r_neg;
  logic [CntW-1:0]  r_cnt;
  logic [PW-1:0]    r_prod, r_mcand;
  logic [XLEN-1:0]  r_mplier, r_divisor, r_rem, r_quo, r_data;

  logic            w_accept, w_sa, w_sb, w_is_div, w_is_rem, w_neg;
  logic            w_div0, w_ovf, w_fast, w_last, w_is_mul_run;
  logic [XLEN-1:0] w_a, w_b, w_a_mag, w_b_mag, w_fast_data;
  logic [PW-1:0]   w_prod_next, w_prod_fin;
  logic [XLEN:0]   w_shift, w_trial;
  logic [XLEN-1:0] w_rem_next, w_quo_next, w_mplier_next, w_quo_fin, w_rem_fin, w_run_data;

  assign w_req = '{op: MD_OP'(bus.req_op), a: MD_W_MAX'(bus.req_a), b: MD_W_MAX'(bus.req_b),
                   tag: MD_TAG_W_MAX'(bus.req_tag)};

  // Operand decode at acceptance
  assign w_accept = bus.req_valid & bus.req_ready & ~flush;
  assign w_sa     = fn_md_is_signed(w_req.op, 1'b0);
  assign w_sb     = fn_md_is_signed(w_req.op, 1'b1);
  assign w_a      = XLEN'(w_req.a);
  assign w_b      = XLEN'(w_req.b);
  assign w_a_mag  = XLEN'(fn_md_abs(w_req.a, w_sa, XLEN));
  assign w_b_mag  = XLEN'(fn_md_abs(w_req.b, w_sb, XLEN));
  assign w_is_div = w_req.op[2];
  assign w_is_rem = w_req.op[2] & w_req.op[1];
  assign w_neg    = (w_sa & w_a[XLEN-1]) ^ (w_sb & w_b[XLEN-1] & ~w_is_rem);
  assign w_div0   = w_is_div & (w_b == '0);
  assign w_ovf    = w_is_div & ~w_req.op[0] & (w_a == {1'b1, {(XLEN-1){1'b0}}}) & (w_b == '1);
  assign w_fast   = w_div0 | w_ovf;

  always_comb begin
    w_fast_data = '0;
    if (w_div0)     w_fast_data = w_is_rem ? w_a : '1;
    else if (w_ovf) w_fast_data = w_is_rem ? '0 : w_a;
  end

  // One radix-2 step of each datapath
  assign w_prod_next   = r_mplier[0] ? r_prod + r_mcand : r_prod;
  assign w_mplier_next = r_mplier >> 1;
  assign w_shift       = {r_rem, r_quo[XLEN-1]};
  assign w_trial       = w_shift - {1'b0, r_divisor};
  assign w_rem_next    = w_trial[XLEN] ? w_shift[XLEN-1:0] : w_trial[XLEN-1:0];
  assign w_quo_next    = {r_quo[XLEN-2:0], ~w_trial[XLEN]};
  assign w_is_mul_run  = ~r_op[2];

`ifdef MULDIV_EARLY_OUT_EN
  assign w_last = (r_cnt == '0) | (w_is_mul_run & (w_mplier_next == '0));
`else
  assign w_last = (r_cnt == '0);
`endif

  assign w_prod_fin = r_neg ? PW'(fn_md_neg(MD_W_MAX'(w_prod_next))) : w_prod_next;
  assign w_quo_fin  = r_neg ? XLEN'(fn_md_neg(MD_W_MAX'(w_quo_next))) : w_quo_next;
  assign w_rem_fin  = r_neg ? XLEN'(fn_md_neg(MD_W_MAX'(w_rem_next))) : w_rem_next;

  always_comb begin
    w_run_data = '0;
    unique case (r_op)
      OpMul:                     w_run_data = w_prod_fin[XLEN-1:0];
      OpMulh, OpMulhsu, OpMulhu: w_run_data = w_prod_fin[PW-1:XLEN];
      OpDiv, OpDivu:             w_run_data = w_quo_fin;
      OpRem, OpRemu:             w_run_data = w_rem_fin;
      default:                   w_run_data = '0;
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= StIdle;
    else        r_state <= w_state_next;
  end

  // FSM: next state; flush wins over the response handshake
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_accept) w_state_next = w_fast ? StDone : StRun;
      StRun:   if (flush) w_state_next = StIdle;
               else if (w_last) w_state_next = StDone;
      StDone:  if (flush || bus.resp_ready) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    bus.req_ready  = (r_state == StIdle);
    bus.resp_valid = (r_state == StDone);
    busy           = (r_state != StIdle);
    bus.resp_data  = r_data;
    bus.resp_tag   = r_tag;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op      <= OpMul;
      r_tag     <= '0;
      r_neg     <= 1'b0;
      r_cnt     <= '0;
      r_prod    <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_divisor <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_data    <= '0;
    end else if (w_accept) begin
      r_op      <= w_req.op;
      r_tag     <= TAG_W'(w_req.tag);
      r_neg     <= w_neg;
      r_cnt     <= CntW'(XLEN - 1);
      r_prod    <= '0;
      r_mcand   <= PW'(w_a_mag);
      r_mplier  <= w_b_mag;
      r_divisor <= w_b_mag;
      r_rem     <= '0;
      r_quo     <= w_a_mag;
      if (w_fast) r_data <= w_fast_data;
    end else if (r_state == StRun && !flush) begin
      r_cnt    <= r_cnt - CntW'(1);
      r_prod   <= w_prod_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= w_mplier_next;
      r_rem    <= w_rem_next;
      r_quo    <= w_quo_next;
      if (w_last) r_data <= w_run_data;
    end
  end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Self-checking bench for alu_muldiv_seq (XLEN=32): transaction model plus directed vectors.
module tb_alu_muldiv_seq;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned TAG_W = 5;

  logic clk;
  logic rst_n;
  logic flush;
  logic busy;

  alu_muldiv_seq_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

  alu_muldiv_seq #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus.slave),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Result from the arithmetic definition of each op
  function automatic logic [31:0] fn_model(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    longint     sa, sb, ua, ub;
    logic [63:0] p;
    logic        ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'b0, a});
    ub  = longint'({32'b0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = '0;
    case (op)
      3'd0: begin p = sa * sb; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int fn_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2] && (b == 0)) return 1;
    if (op[2] && !op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return XLEN + 1;
  endfunction

  // Transaction model: pending op, edges since acceptance, expected result
  bit          m_pending = 1'b0;
  int          m_since   = 0;
  int          m_lat     = 1;
  logic [31:0] m_data    = '0;
  logic [4:0]  m_tag     = '0;

  function automatic bit fn_m_valid();
    return m_pending && (m_since >= m_lat - 1);
  endfunction

  always @(posedge clk) begin
    if (!rst_n || flush) begin
      m_pending = 1'b0;
    end else if (m_pending) begin
      if (fn_m_valid() && bus.resp_ready) m_pending = 1'b0;
      else m_since++;
    end else if (bus.req_valid) begin
      m_pending = 1'b1;
      m_since   = 0;
      m_lat     = fn_lat(bus.req_op, bus.req_a, bus.req_b);
      m_data    = fn_model(bus.req_op, bus.req_a, bus.req_b);
      m_tag     = bus.req_tag;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("resp_valid", 32'(bus.resp_valid), 32'(fn_m_valid()));
      chk("req_ready", 32'(bus.req_ready), 32'(!m_pending));
      chk("busy", 32'(busy), 32'(m_pending));
      if (fn_m_valid()) begin
        chk("resp_data", bus.resp_data, m_data);
        chk("resp_tag", 32'(bus.resp_tag), 32'(m_tag));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] tag, input logic [31:0] exp,
                        input int exp_lat, input int hold);
    int n;
    chk({name, "_pin"}, fn_model(op, a, b), exp);
    bus.req_valid  = 1'b1;
    bus.req_op     = op;
    bus.req_a      = a;
    bus.req_b      = b;
    bus.req_tag    = tag;
    bus.resp_ready = (hold == 0);
    tick();
    bus.req_valid = 1'b0;
    n = 0;
    while (!bus.resp_valid && n < 100) begin
      tick();
      n++;
    end
    if (!bus.resp_valid) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: no resp_valid within 100 cycles", name);
    end else begin
      chk({name, "_data"}, bus.resp_data, exp);
      chk({name, "_tag"}, 32'(bus.resp_tag), 32'(tag));
      chk({name, "_lat"}, 32'(n + 1), 32'(exp_lat));
    end
    if (hold > 0) begin
      repeat (hold) tick();
      chk({name, "_hold_data"}, bus.resp_data, exp);
      chk({name, "_hold_ready"}, 32'(bus.req_ready), 32'd0);
      bus.resp_ready = 1'b1;
    end
    tick();
    chk({name, "_ready_after"}, 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    rst_n          = 1'b0;
    flush          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_op     = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.req_tag    = '0;
    bus.resp_ready = 1'b1;
    repeat (2) tick();
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_data", bus.resp_data, 32'd0);
    chk("rst_resp_tag", 32'(bus.resp_tag), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    run_op("mul",     3'd0, 32'd7,          32'd6,          5'h11, 32'd42,         33, 0);
    run_op("mulh",    3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'h01, 32'h0000_0000,  33, 0);
    run_op("mulhu",   3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'h02, 32'hFFFF_FFFE,  33, 0);
    run_op("mulhsu",  3'd2, 32'hFFFF_FFFF,  32'd2,          5'h03, 32'hFFFF_FFFF,  33, 0);
    run_op("div",     3'd4, 32'hFFFF_FFF9,  32'd2,          5'h04, 32'hFFFF_FFFD,  33, 0);
    run_op("rem",     3'd6, 32'hFFFF_FFF9,  32'd2,          5'h05, 32'hFFFF_FFFF,  33, 0);
    run_op("divu",    3'd5, 32'd100,        32'd7,          5'h06, 32'd14,         33, 0);
    run_op("remu",    3'd7, 32'd100,        32'd7,          5'h07, 32'd2,          33, 0);
    run_op("divu0",   3'd5, 32'd5,          32'd0,          5'h08, 32'hFFFF_FFFF,  1,  0);
    run_op("remu0",   3'd7, 32'd5,          32'd0,          5'h09, 32'd5,          1,  0);
    run_op("div_ovf", 3'd4, 32'h8000_0000,  32'hFFFF_FFFF,  5'h0A, 32'h8000_0000,  1,  0);
    run_op("rem_ovf", 3'd6, 32'h8000_0000,  32'hFFFF_FFFF,  5'h0B, 32'h0,          1,  0);
    run_op("mul_neg", 3'd0, 32'hFFFF_FFFD,  32'd5,          5'h0C, 32'hFFFF_FFF1,  33, 0);
    run_op("div_nb",  3'd4, 32'd7,          32'hFFFF_FFFE,  5'h0D, 32'hFFFF_FFFD,  33, 0);
    run_op("rem_nb",  3'd6, 32'd7,          32'hFFFF_FFFE,  5'h0E, 32'd1,          33, 0);
    run_op("mulh_mn", 3'd1, 32'h8000_0000,  32'h8000_0000,  5'h0F, 32'h4000_0000,  33, 0);
    run_op("hold",    3'd3, 32'h1234_5678,  32'h10,         5'h1F, 32'h1,          33, 4);

    // Flush ten cycles into RUN: no response, ready again next cycle
    bus.req_valid = 1'b1;
    bus.req_op    = 3'd5;
    bus.req_a     = 32'd1000;
    bus.req_b     = 32'd3;
    bus.req_tag   = 5'h12;
    tick();
    bus.req_valid = 1'b0;
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_ready", 32'(bus.req_ready), 32'd1);
    chk("flush_busy", 32'(busy), 32'd0);
    repeat (40) tick();
    run_op("post_flush", 3'd5, 32'd1000, 32'd3, 5'h13, 32'd333, 33, 0);

    // Flush in IDLE blocks acceptance
    bus.req_valid = 1'b1;
    flush         = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    flush         = 1'b0;
    chk("idle_flush_busy", 32'(busy), 32'd0);
    repeat (3) tick();

    // Reset in the middle of RUN
    bus.req_valid = 1'b1;
    bus.req_op    = 3'd0;
    bus.req_a     = 32'd9;
    bus.req_b     = 32'd9;
    bus.req_tag   = 5'h15;
    tick();
    bus.req_valid = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    tick();
    chk("mid_rst_valid", 32'(bus.resp_valid), 32'd0);
    chk("mid_rst_data", bus.resp_data, 32'd0);
    chk("mid_rst_tag", 32'(bus.resp_tag), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(bus.req_ready), 32'd1);
    rst_n = 1'b1;
    run_op("post_rst_mul",   3'd0, 32'h0001_0000, 32'h0001_0000, 5'h16, 32'h0, 33, 0);
    run_op("post_rst_mulhu", 3'd3, 32'h0001_0000, 32'h0001_0000, 5'h17, 32'h1, 33, 0);

    repeat (3) tick();
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
